// File: rtl/spi_pkg.sv
// Shared types for the parametrised SPI slave front-end: FSM state encoding,
// command codes of the SPI-to-RAM protocol and a small state classifier.
package spi_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      CHK_CMD   = 3'd1,
      WRITE     = 3'd2,
      READ_ADD  = 3'd3,
      READ_DATA = 3'd4,
      WAIT_TX   = 3'd5,
      TX_SHIFT  = 3'd6,
      DONE      = 3'd7
   } spi_state_e;

   // Upper two bits of a received word as interpreted by the RAM wrapper.
   localparam logic [1:0] CMD_WR_ADDR = 2'b00;
   localparam logic [1:0] CMD_WR_DATA = 2'b01;
   localparam logic [1:0] CMD_RD_ADDR = 2'b10;
   localparam logic [1:0] CMD_RD_DATA = 2'b11;

   function automatic logic is_rx_state(input spi_state_e s);
      return (s == WRITE) || (s == READ_ADD) || (s == READ_DATA);
   endfunction

endpackage

// File: rtl/spi_shifter.sv
// Shift register usable as serial-in/parallel-out or parallel-in/serial-out.
// LSB_FIRST=1 shifts towards bit 0 (serial out at [0], serial in at MSB).
module spi_shifter #(
   parameter int WIDTH     = 8,
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_en,
   input  logic [WIDTH-1:0] load_data,
   input  logic             shift_en,
   input  logic             ser_i,
   output logic [WIDTH-1:0] par_next_o,
   output logic             ser_o
);

   logic [WIDTH-1:0] sr_q, sr_d;
   logic [WIDTH-1:0] shifted;
   logic [WIDTH+1:0] wide;

   // Padding the register with the serial input on both ends makes either
   // shift direction a plain slice, valid down to WIDTH=1.
   always_comb begin
      wide    = {ser_i, sr_q, ser_i};
      shifted = LSB_FIRST ? wide[WIDTH+1:2] : wide[WIDTH-1:0];
      sr_d    = sr_q;
      if (load_en) begin
         sr_d = load_data;
      end else if (shift_en) begin
         sr_d = shifted;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sr_q <= '0;
      end else begin
         sr_q <= sr_d;
      end
   end

   assign par_next_o = sr_d;
   assign ser_o      = LSB_FIRST ? sr_q[0] : sr_q[WIDTH-1];

endmodule

// File: rtl/spi_slave_param.sv
// SPI slave front-end: receives DATA_W+2 bit words after a direction bit,
// serves read data from tx_data, and flags aborted or timed-out frames.
module spi_slave_param
   import spi_pkg::*;
#(
   parameter int DATA_W       = 8,
   parameter bit RX_LSB_FIRST = 1'b1,
   parameter bit TX_LSB_FIRST = 1'b0,
   parameter int TX_TIMEOUT   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              SS_n,
   input  logic              MOSI,
   output logic              MISO,
   output logic [DATA_W+1:0] rx_data,
   output logic              rx_valid,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              frame_err,
   output logic              busy
);

   localparam int W     = DATA_W + 2;
   localparam int CNT_W = $clog2(W + 1);
   localparam int TO_W  = $clog2(TX_TIMEOUT + 1);

   localparam logic [CNT_W-1:0] RX_LAST = CNT_W'(W - 1);
   localparam logic [CNT_W-1:0] TX_LAST = CNT_W'(DATA_W - 1);
   localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TX_TIMEOUT - 1);

   spi_state_e        state_q, state_d;
   logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
   logic              rd_addr_seen_q, rd_addr_seen_d;
   logic [W-1:0]      rx_data_q, rx_data_d;
   logic              rx_valid_q, rx_valid_d;
   logic              frame_err_q, frame_err_d;

   logic              rx_shift_en;
   logic              tx_load_en;
   logic              tx_shift_en;
   logic [W-1:0]      rx_next;
   logic              rx_ser;
   logic [DATA_W-1:0] tx_next;
   logic              tx_ser;
   logic              unused_bits;

   spi_shifter #(
      .WIDTH     (W),
      .LSB_FIRST (RX_LSB_FIRST)
   ) u_rx_shifter (
      .clk        (clk),
      .rst        (rst),
      .load_en    (1'b0),
      .load_data  ({W{1'b0}}),
      .shift_en   (rx_shift_en),
      .ser_i      (MOSI),
      .par_next_o (rx_next),
      .ser_o      (rx_ser)
   );

   spi_shifter #(
      .WIDTH     (DATA_W),
      .LSB_FIRST (TX_LSB_FIRST)
   ) u_tx_shifter (
      .clk        (clk),
      .rst        (rst),
      .load_en    (tx_load_en),
      .load_data  (tx_data),
      .shift_en   (tx_shift_en),
      .ser_i      (1'b0),
      .par_next_o (tx_next),
      .ser_o      (tx_ser)
   );

   assign unused_bits = ^{rx_ser, tx_next};

   always_comb begin
      state_d        = state_q;
      bit_cnt_d      = bit_cnt_q;
      to_cnt_d       = to_cnt_q;
      rd_addr_seen_d = rd_addr_seen_q;
      rx_data_d      = rx_data_q;
      rx_valid_d     = 1'b0;
      frame_err_d    = 1'b0;
      rx_shift_en    = is_rx_state(state_q) && !SS_n;
      tx_load_en     = 1'b0;
      tx_shift_en    = 1'b0;

      case (state_q)
         IDLE: begin
            if (!SS_n) state_d = CHK_CMD;
         end
         CHK_CMD: begin
            if (SS_n) begin
               state_d = IDLE;
            end else begin
               bit_cnt_d = '0;
               if (!MOSI)               state_d = WRITE;
               else if (rd_addr_seen_q) state_d = READ_DATA;
               else                     state_d = READ_ADD;
            end
         end
         WRITE, READ_ADD, READ_DATA: begin
            if (SS_n) begin
               frame_err_d = 1'b1;
               state_d     = IDLE;
            end else if (bit_cnt_q == RX_LAST) begin
               rx_data_d  = rx_next;
               rx_valid_d = 1'b1;
               to_cnt_d   = '0;
               if (state_q == READ_DATA) begin
                  state_d = WAIT_TX;
               end else begin
                  state_d = DONE;
                  if (state_q == READ_ADD) rd_addr_seen_d = 1'b1;
               end
            end else begin
               bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
         end
         WAIT_TX: begin
            // Deselect beats a simultaneous tx_valid: the frame is gone.
            if (SS_n) begin
               frame_err_d = 1'b1;
               state_d     = IDLE;
            end else if (tx_valid) begin
               tx_load_en = 1'b1;
               bit_cnt_d  = '0;
               state_d    = TX_SHIFT;
            end else if (to_cnt_q == TO_LAST) begin
               frame_err_d = 1'b1;
               state_d     = DONE;
            end else begin
               to_cnt_d = to_cnt_q + TO_W'(1);
            end
         end
         TX_SHIFT: begin
            if (SS_n) begin
               frame_err_d = 1'b1;
               state_d     = IDLE;
            end else if (bit_cnt_q == TX_LAST) begin
               rd_addr_seen_d = 1'b0;
               state_d        = DONE;
            end else begin
               tx_shift_en = 1'b1;
               bit_cnt_d   = bit_cnt_q + CNT_W'(1);
            end
         end
         DONE: begin
            if (SS_n) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         bit_cnt_q      <= '0;
         to_cnt_q       <= '0;
         rd_addr_seen_q <= 1'b0;
         rx_data_q      <= '0;
         rx_valid_q     <= 1'b0;
         frame_err_q    <= 1'b0;
      end else begin
         state_q        <= state_d;
         bit_cnt_q      <= bit_cnt_d;
         to_cnt_q       <= to_cnt_d;
         rd_addr_seen_q <= rd_addr_seen_d;
         rx_data_q      <= rx_data_d;
         rx_valid_q     <= rx_valid_d;
         frame_err_q    <= frame_err_d;
      end
   end

   assign MISO      = (state_q == TX_SHIFT) && tx_ser;
   assign rx_data   = rx_data_q;
   assign rx_valid  = rx_valid_q;
   assign frame_err = frame_err_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_spi_slave_param.sv
// Directed bench for spi_slave_param: a default instance and a wide,
// reversed-bit-order instance, checked every cycle against a frame-level model.
module tb_spi_slave_param;

   localparam int TO = 16;

   logic        clk;
   logic        rst;
   logic        ss_a, mosi_a, miso_a, rxv_a, txv_a, fe_a, busy_a;
   logic [9:0]  rx_a;
   logic [7:0]  txd_a;
   logic        ss_b, mosi_b, miso_b, rxv_b, txv_b, fe_b, busy_b;
   logic [17:0] rx_b;
   logic [15:0] txd_b;

   // Expected outputs after the most recent clock edge, per instance.
   logic        exp_rxv [2];
   logic        exp_fe  [2];
   logic        exp_busy[2];
   logic        exp_miso[2];
   logic [17:0] exp_rxd [2];
   logic [17:0] nxt_rxd [2];
   // Frame-level model: read address already given / frame waiting for data.
   logic        seen    [2];
   logic        wait_tx [2];

   logic        chk_en;
   int          n_checks;
   int          n_errors;

   spi_slave_param u_dut_a (
      .clk       (clk),
      .rst       (rst),
      .SS_n      (ss_a),
      .MOSI      (mosi_a),
      .MISO      (miso_a),
      .rx_data   (rx_a),
      .rx_valid  (rxv_a),
      .tx_data   (txd_a),
      .tx_valid  (txv_a),
      .frame_err (fe_a),
      .busy      (busy_a)
   );

   spi_slave_param #(
      .DATA_W       (16),
      .RX_LSB_FIRST (1'b0),
      .TX_LSB_FIRST (1'b1),
      .TX_TIMEOUT   (TO)
   ) u_dut_b (
      .clk       (clk),
      .rst       (rst),
      .SS_n      (ss_b),
      .MOSI      (mosi_b),
      .MISO      (miso_b),
      .rx_data   (rx_b),
      .rx_valid  (rxv_b),
      .tx_data   (txd_b),
      .tx_valid  (txv_b),
      .frame_err (fe_b),
      .busy      (busy_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int wid(input int sel);
      return (sel == 0) ? 10 : 18;
   endfunction

   function automatic int dwid(input int sel);
      return (sel == 0) ? 8 : 16;
   endfunction

   function automatic logic rx_lsb(input int sel);
      return sel == 0;
   endfunction

   function automatic logic txbit(input int sel, input logic [15:0] td, input int j);
      return (sel == 1) ? td[j] : td[dwid(sel)-1-j];
   endfunction

   task automatic check(input string name, input logic [17:0] act, input logic [17:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("a_rx_valid",  18'(rxv_a),  18'(exp_rxv[0]));
         check("a_frame_err", 18'(fe_a),   18'(exp_fe[0]));
         check("a_busy",      18'(busy_a), 18'(exp_busy[0]));
         check("a_miso",      18'(miso_a), 18'(exp_miso[0]));
         check("a_rx_data",   18'(rx_a),   exp_rxd[0]);
         check("b_rx_valid",  18'(rxv_b),  18'(exp_rxv[1]));
         check("b_frame_err", 18'(fe_b),   18'(exp_fe[1]));
         check("b_busy",      18'(busy_b), 18'(exp_busy[1]));
         check("b_miso",      18'(miso_b), 18'(exp_miso[1]));
         check("b_rx_data",   rx_b,        exp_rxd[1]);
      end
   end

   // One clock: drive inputs, take the edge, then publish what must follow it.
   task automatic step(input int sel, input logic ss, input logic mosi, input logic tv,
                       input logic [15:0] td, input logic rxv, input logic fe,
                       input logic bsy, input logic miso);
      if (sel == 0) begin
         ss_a = ss; mosi_a = mosi; txv_a = tv; txd_a = td[7:0];
      end else begin
         ss_b = ss; mosi_b = mosi; txv_b = tv; txd_b = td;
      end
      @(posedge clk);
      #1;
      exp_rxv[sel]  = rxv;
      exp_fe[sel]   = fe;
      exp_busy[sel] = bsy;
      exp_miso[sel] = miso;
      if (rxv) exp_rxd[sel] = nxt_rxd[sel];
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      ss_a = 1'b1; mosi_a = 1'b0; txv_a = 1'b0; txd_a = '0;
      ss_b = 1'b1; mosi_b = 1'b0; txv_b = 1'b0; txd_b = '0;
      @(posedge clk);
      #1;
      for (int s = 0; s < 2; s++) begin
         exp_rxv[s] = 1'b0; exp_fe[s] = 1'b0; exp_busy[s] = 1'b0; exp_miso[s] = 1'b0;
         exp_rxd[s] = '0; nxt_rxd[s] = '0; seen[s] = 1'b0; wait_tx[s] = 1'b0;
      end
      chk_en = 1'b1;
      repeat (n - 1) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b0;
   endtask

   task automatic idle(input int sel, input int n);
      repeat (n) step(sel, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic end_frame(input int sel);
      step(sel, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // Select, direction bit, then the word; abort_at deselects instead of that bit.
   task automatic send_frame(input int sel, input logic dir, input logic [17:0] word,
                             input int abort_at, input logic tv_noise);
      int   w;
      logic b;
      w = wid(sel);
      wait_tx[sel] = 1'b0;
      step(sel, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0);
      step(sel, 1'b0, dir,  1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < w; i++) begin
         if (i == abort_at) begin
            step(sel, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0);
            return;
         end
         b = rx_lsb(sel) ? word[i] : word[w-1-i];
         if (i == w - 1) begin
            nxt_rxd[sel] = word;
            step(sel, 1'b0, b, tv_noise & i[0], 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0);
         end else begin
            step(sel, 1'b0, b, tv_noise & i[0], 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0);
         end
      end
      if (dir) begin
         if (seen[sel]) wait_tx[sel] = 1'b1;
         else           seen[sel]    = 1'b1;
      end
   endtask

   // Offer tx_data after `delay` idle cycles; stop_at returns after that many bits.
   task automatic send_tx(input int sel, input logic [15:0] td, input int delay,
                          input int stop_at, output logic [15:0] cap);
      cap = '0;
      if (!wait_tx[sel]) begin
         step(sel, 1'b0, 1'b0, 1'b1, td, 1'b0, 1'b0, 1'b1, 1'b0);
         return;
      end
      repeat (delay) step(sel, 1'b0, 1'b0, 1'b0, td, 1'b0, 1'b0, 1'b1, 1'b0);
      for (int j = 0; j < dwid(sel); j++) begin
         if (j == stop_at) return;
         step(sel, 1'b0, 1'b0, (j == 0), td, 1'b0, 1'b0, 1'b1, txbit(sel, td, j));
         cap = {cap[14:0], (sel == 0) ? miso_a : miso_b};
      end
      step(sel, 1'b0, 1'b0, 1'b0, td, 1'b0, 1'b0, 1'b1, 1'b0);
      wait_tx[sel] = 1'b0;
      seen[sel]    = 1'b0;
   endtask

   task automatic time_out(input int sel);
      for (int k = 1; k <= TO; k++)
         step(sel, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, wait_tx[sel] && (k == TO), 1'b1, 1'b0);
      wait_tx[sel] = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] cap;
      n_checks = 0;
      n_errors = 0;
      chk_en   = 1'b0;
      do_reset(3);
      check("rst_rx_data", 18'(rx_a), 18'h0);
      check("rst_busy", 18'(busy_a), 18'h0);
      idle(0, 2);

      // Write frame, then extra bits and a stray tx_valid in DONE.
      send_frame(0, 1'b0, 18'h0A5, -1, 1'b1);
      check("wr_rx_data", 18'(rx_a), 18'h0A5);
      check("wr_rx_valid", 18'(rxv_a), 18'h1);
      step(0, 1'b0, 1'b1, 1'b1, 16'hFF, 1'b0, 1'b0, 1'b1, 1'b0);
      end_frame(0);

      // Read address, then read data served with 8'h3C.
      send_frame(0, 1'b1, 18'h27F, -1, 1'b0);
      check("ra_rx_data", 18'(rx_a), 18'h27F);
      end_frame(0);
      send_frame(0, 1'b1, 18'h300, -1, 1'b0);
      check("rd_rx_data", 18'(rx_a), 18'h300);
      send_tx(0, 16'h003C, 2, -1, cap);
      check("rd_miso_seq", 18'(cap), 18'h0003C);
      end_frame(0);

      // Abort after five data bits.
      send_frame(0, 1'b0, 18'h155, 5, 1'b0);
      check("abort_busy", 18'(busy_a), 18'h0);
      check("abort_ferr", 18'(fe_a), 18'h1);
      idle(0, 1);
      check("abort_rx_kept", 18'(rx_a), 18'h300);

      // Timeout keeps the read address; the next read goes straight to data.
      send_frame(0, 1'b1, 18'h1AA, -1, 1'b0);
      end_frame(0);
      send_frame(0, 1'b1, 18'h3FF, -1, 1'b0);
      time_out(0);
      check("to_ferr", 18'(fe_a), 18'h1);
      end_frame(0);
      send_frame(0, 1'b1, 18'h2C3, -1, 1'b0);
      send_tx(0, 16'h0096, 0, -1, cap);
      check("to_next_miso_seq", 18'(cap), 18'h00096);
      end_frame(0);

      // Reset in the middle of a read-data transfer.
      send_frame(0, 1'b1, 18'h201, -1, 1'b0);
      end_frame(0);
      send_frame(0, 1'b1, 18'h3A0, -1, 1'b0);
      send_tx(0, 16'h00F0, 0, 3, cap);
      do_reset(2);
      check("mid_rst_miso", 18'(miso_a), 18'h0);
      check("mid_rst_rx_data", 18'(rx_a), 18'h0);
      send_frame(0, 1'b1, 18'h211, -1, 1'b0);
      send_tx(0, 16'h00FF, 0, -1, cap);
      end_frame(0);

      // Deselect in CHK_CMD, on the final bit, in WAIT_TX with tx_valid, in TX_SHIFT.
      step(0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0);
      step(0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      send_frame(0, 1'b0, 18'h3FF, 9, 1'b0);
      check("last_bit_abort_rx", 18'(rx_a), 18'h211);
      idle(0, 1);
      send_frame(0, 1'b1, 18'h3C5, -1, 1'b0);
      step(0, 1'b1, 1'b0, 1'b1, 16'h55, 1'b0, 1'b1, 1'b0, 1'b0);
      wait_tx[0] = 1'b0;
      idle(0, 1);
      send_frame(0, 1'b1, 18'h3C6, -1, 1'b0);
      send_tx(0, 16'h00A5, 0, 2, cap);
      step(0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0);
      wait_tx[0] = 1'b0;
      idle(0, 1);
      send_frame(0, 1'b1, 18'h3C7, -1, 1'b0);
      send_tx(0, 16'h0081, 1, -1, cap);
      check("after_aborts_miso_seq", 18'(cap), 18'h00081);
      end_frame(0);

      // Wide instance: MSB-first receive, LSB-first transmit.
      idle(1, 2);
      send_frame(1, 1'b0, 18'h2A5C3, -1, 1'b0);
      check("b_wr_rx_data", rx_b, 18'h2A5C3);
      end_frame(1);
      send_frame(1, 1'b1, 18'h30001, -1, 1'b0);
      end_frame(1);
      send_frame(1, 1'b1, 18'h3FFFF, -1, 1'b0);
      send_tx(1, 16'h8001, 1, -1, cap);
      check("b_miso_seq", 18'(cap), 18'h08001);
      end_frame(1);
      send_frame(1, 1'b1, 18'h30002, -1, 1'b0);
      end_frame(1);
      send_frame(1, 1'b1, 18'h3000F, -1, 1'b0);
      send_tx(1, 16'h00C1, 0, -1, cap);
      check("b_miso_seq2", 18'(cap), 18'h08300);
      end_frame(1);
      idle(1, 2);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
